// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller: opcodes, issue classes and the queue entry payload.
package issue_ctrl_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned OPCODE_W = 7;

    // Word-wide range type shared by instruction and PC fields
    typedef logic [WORD_W-1:0] word_t;

    localparam logic [OPCODE_W-1:0] LUI_OPCODE       = 7'b0110111;
    localparam logic [OPCODE_W-1:0] AUIPC_OPCODE     = 7'b0010111;
    localparam logic [OPCODE_W-1:0] JAL_OPCODE       = 7'b1101111;
    localparam logic [OPCODE_W-1:0] JALR_OPCODE      = 7'b1100111;
    localparam logic [OPCODE_W-1:0] BRANCH_OPCODE    = 7'b1100011;
    localparam logic [OPCODE_W-1:0] LOAD_OPCODE      = 7'b0000011;
    localparam logic [OPCODE_W-1:0] STORE_OPCODE     = 7'b0100011;
    localparam logic [OPCODE_W-1:0] ARITH_IMM_OPCODE = 7'b0010011;
    localparam logic [OPCODE_W-1:0] ARITH_OPCODE     = 7'b0110011;

    typedef enum logic [1:0] {
        ISSUE_CLASS_RS  = 2'd0,
        ISSUE_CLASS_LSB = 2'd1,
        ISSUE_CLASS_ILL = 2'd2
    } issue_class_t;

    typedef struct packed {
        word_t pc;
        word_t inst;
    } queue_entry_t;

    localparam int unsigned ENTRY_W = $bits(queue_entry_t);

    // Map an opcode to the station that will receive it
    function automatic issue_class_t classify_opcode(input logic [OPCODE_W-1:0] opcode);
        issue_class_t cls;
        case (opcode)
            LOAD_OPCODE, STORE_OPCODE: cls = ISSUE_CLASS_LSB;
            LUI_OPCODE, AUIPC_OPCODE, JAL_OPCODE, JALR_OPCODE,
            BRANCH_OPCODE, ARITH_IMM_OPCODE, ARITH_OPCODE: cls = ISSUE_CLASS_RS;
            default: cls = ISSUE_CLASS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/issue_ctrl_inst_queue.sv
// In-order circular FIFO of {pc, inst} entries with synchronous clear.
module inst_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             do_push;
    logic             do_pop;

    // A full queue refuses pushes even when the head pops in the same cycle
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[head_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (en) begin
            if (clear) begin
                head_ptr <= '0;
                tail_ptr <= '0;
                count    <= '0;
            end else begin
                if (do_push) tail_ptr <= tail_ptr + PTR_W'(1);
                if (do_pop)  head_ptr <= head_ptr + PTR_W'(1);
                count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            end
        end
    end

    // Storage carries no reset; validity is tracked by count alone
    always_ff @(posedge clk) begin
        if (en && !rst && !clear && do_push) begin
            mem[tail_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: buffers fetched instructions, classifies the head and strobes issue when resources allow.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   fet_valid_in,
    input  logic [WORD_W-1:0]      fet_inst_in,
    input  logic [WORD_W-1:0]      fet_pc_in,
    output logic                   fet_ready_out,
    output logic                   dec_issue_signal_out,
    output logic [WORD_W-1:0]      dec_inst_out,
    output logic [WORD_W-1:0]      dec_pc_out,
    input  logic                   rob_full_in,
    input  logic                   rs_full_in,
    input  logic                   lsb_full_in,
    input  logic                   rob_flush_in,
    output logic                   illegal_out,
    output logic [STALL_CNT_W-1:0] stall_cnt_out
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t       state;
    state_t       next_state;
    queue_entry_t push_entry;
    queue_entry_t head_entry;
    logic [ENTRY_W-1:0] head_raw;
    logic         q_full;
    logic         q_empty;
    logic [CNT_W-1:0] q_count;
    issue_class_t head_class;
    logic         run;
    logic         head_valid;
    logic         target_full;
    logic         stall;
    logic         q_push;
    logic         q_pop;

    assign push_entry = {fet_pc_in, fet_inst_in};
    assign head_entry = queue_entry_t'(head_raw);
    assign head_class = classify_opcode(head_entry.inst[OPCODE_W-1:0]);

    inst_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .push      (q_push),
        .pop       (q_pop),
        .clear     (rob_flush_in),
        .push_data (push_entry),
        .head_data (head_raw),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next state, issue decision and head presentation
    always_comb begin
        next_state           = state;
        run                  = rdy && !rst && (state == ST_RUN);
        head_valid           = (q_count != '0);
        target_full          = (head_class == ISSUE_CLASS_RS) ? rs_full_in : lsb_full_in;
        fet_ready_out        = FALSE;
        dec_issue_signal_out = FALSE;
        illegal_out          = FALSE;
        stall                = FALSE;
        dec_inst_out         = q_empty ? '0 : head_entry.inst;
        dec_pc_out           = q_empty ? '0 : head_entry.pc;

        if (run) begin
            fet_ready_out = !q_full;
            if (head_valid && !rob_flush_in) begin
                if (head_class == ISSUE_CLASS_ILL) begin
                    illegal_out = TRUE;
                end else if (rob_full_in || target_full) begin
                    stall = TRUE;
                end else begin
                    dec_issue_signal_out = TRUE;
                end
            end
        end

        q_push = fet_valid_in && fet_ready_out && !rob_flush_in;
        q_pop  = dec_issue_signal_out || illegal_out;

        if (rdy) begin
            case (state)
                ST_RUN:   if (rob_flush_in)  next_state = ST_FLUSH;
                ST_FLUSH: if (!rob_flush_in) next_state = ST_RUN;
                default:  next_state = ST_RUN;
            endcase
        end
    end

    // Saturating resource-stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_out <= '0;
        end else if (stall && (stall_cnt_out != '1)) begin
            stall_cnt_out <= stall_cnt_out + STALL_CNT_W'(1);
        end
    end

endmodule
